// File: rtl/instruction_decoder.sv
// Decode/operand-read stage: assembles V850 16/32-bit formats from halfwords,
// reads GR/PSW, and issues one registered operand bundle per cycle with hazard bubbles.
module instruction_decoder #(
  parameter logic [4:0] NOP_SEL = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_i,
  input  logic [31:0] instr_pc_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] GR_i [0:31],
  input  logic [31:0] PSW_i,
  output logic [4:0]  destination_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [31:0] reg3_o,
  output logic        increment_bit_o,
  output logic [4:0]  circuit_sel_o,
  output logic        flush_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {FIRST, SECOND, STALL} state_t;

  state_t      state;
  logic [15:0] first_hw;
  logic [31:0] first_pc;
  logic [15:0] held_hw;
  logic [15:0] held_imm;
  logic [31:0] held_pc;
  logic [4:0]  last_dest;
  logic [4:0]  last_r3;
  logic        last_live;

  logic        accept;
  logic        go;
  logic [15:0] hw_a;
  logic [15:0] hw_b;
  logic [31:0] pc_a;

  logic [5:0]  op;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic        is32;

  logic        sat, cy, ov, s, z;
  logic        base_cond;
  logic        taken;
  logic [31:0] disp;

  logic [4:0]  d_sel;
  logic [4:0]  d_dest;
  logic [31:0] d_reg1;
  logic [31:0] d_reg2;
  logic [31:0] d_reg3;
  logic        d_flush;
  logic        d_illegal;
  logic        d_bcond;
  logic [4:0]  d_src1;
  logic [4:0]  d_src2;
  logic        hazard;

  logic        unused_psw;
  assign unused_psw = ^PSW_i[31:5];

  assign instr_ready_o = !rst && (state != STALL) && !flush_o;
  assign accept        = instr_valid_i && instr_ready_o;

  // Pick the instruction being decoded: live halfword, assembled pair, or the stalled one.
  always_comb begin
    hw_a = instr_i;
    hw_b = '0;
    pc_a = instr_pc_i;
    go   = 1'b0;
    unique case (state)
      FIRST:  go = accept && (instr_i[10:9] != 2'b11);
      SECOND: begin
        hw_a = first_hw;
        hw_b = instr_i;
        pc_a = first_pc;
        go   = accept;
      end
      STALL: begin
        hw_a = held_hw;
        hw_b = held_imm;
        pc_a = held_pc;
        go   = 1'b1;
      end
      default: go = 1'b0;
    endcase
  end

  assign op   = hw_a[10:5];
  assign r1   = hw_a[4:0];
  assign r2   = hw_a[15:11];
  assign is32 = (hw_a[10:9] == 2'b11);
  assign gr1  = (r1 == 5'd0) ? '0 : GR_i[r1];
  assign gr2  = (r2 == 5'd0) ? '0 : GR_i[r2];

  assign sat  = PSW_i[4];
  assign cy   = PSW_i[3];
  assign ov   = PSW_i[2];
  assign s    = PSW_i[1];
  assign z    = PSW_i[0];
  assign disp = {{23{hw_a[15]}}, hw_a[15:11], hw_a[6:4], 1'b0};

  always_comb begin
    base_cond = 1'b0;
    unique case (hw_a[2:0])
      3'd0: base_cond = ov;
      3'd1: base_cond = cy;
      3'd2: base_cond = z;
      3'd3: base_cond = cy | z;
      3'd4: base_cond = s;
      3'd5: base_cond = 1'b1;
      3'd6: base_cond = s ^ ov;
      3'd7: base_cond = (s ^ ov) | z;
      default: base_cond = 1'b0;
    endcase
  end

  // The inverted "always" slot is reused as the SAT test.
  assign taken = (hw_a[3:0] == 4'b1101) ? sat : (base_cond ^ hw_a[3]);

  always_comb begin
    d_sel     = NOP_SEL;
    d_dest    = '0;
    d_reg1    = '0;
    d_reg2    = '0;
    d_reg3    = '0;
    d_flush   = 1'b0;
    d_illegal = 1'b0;
    d_bcond   = 1'b0;
    d_src1    = '0;
    d_src2    = '0;
    if (is32) begin
      unique case (op)
        6'b110000: begin
          d_sel  = 5'b00001;
          d_reg1 = {{16{hw_b[15]}}, hw_b};
          d_reg2 = gr1;
          d_dest = r2;
          d_src1 = r1;
        end
        6'b110110: begin
          d_sel  = 5'b00010;
          d_reg1 = {16'h0000, hw_b};
          d_reg2 = gr1;
          d_dest = r2;
          d_src1 = r1;
        end
        6'b110100: begin
          d_sel  = 5'b00011;
          d_reg1 = {16'h0000, hw_b};
          d_reg2 = gr1;
          d_dest = r2;
          d_src1 = r1;
        end
        6'b111111: begin
          if (hw_b[10:0] == 11'h2C0) begin
            d_sel  = 5'b01000;
            d_reg1 = gr1;
            d_reg2 = gr2;
            d_reg3 = {27'd0, hw_b[15:11]};
            d_dest = r2;
            d_src1 = r1;
            d_src2 = r2;
          end else begin
            d_illegal = 1'b1;
          end
        end
        default: d_illegal = 1'b1;
      endcase
    end else if (hw_a[10:7] == 4'b1011) begin
      d_bcond = 1'b1;
      if (taken) begin
        d_sel   = 5'b00001;
        d_reg1  = disp;
        d_reg2  = pc_a;
        d_flush = 1'b1;
      end
    end else begin
      d_reg1 = gr1;
      d_reg2 = gr2;
      d_dest = r2;
      d_src1 = r1;
      d_src2 = r2;
      unique case (op)
        6'b001110: d_sel = 5'b00001;
        6'b001101: begin
          d_sel  = 5'b00000;
          d_reg1 = 32'd0 - gr1;
        end
        6'b001010: d_sel = 5'b00010;
        6'b001000: d_sel = 5'b00011;
        6'b010010: begin
          d_sel  = 5'b00001;
          d_reg1 = {{27{hw_a[4]}}, hw_a[4:0]};
          d_src1 = '0;
        end
        default: begin
          d_illegal = 1'b1;
          d_reg1    = '0;
          d_reg2    = '0;
          d_dest    = '0;
          d_src1    = '0;
          d_src2    = '0;
        end
      endcase
    end
  end

  function automatic logic raw_hit(input logic [4:0] src, input logic [4:0] dst, input logic [4:0] r3);
    return (src != 5'd0) && ((src == dst) || (src == r3));
  endfunction

  assign hazard = (state != STALL) &&
                  (raw_hit(d_src1, last_dest, last_r3) ||
                   raw_hit(d_src2, last_dest, last_r3) ||
                   (d_bcond && last_live));

  // History only tracks the immediately preceding issue; any bubble resolves a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FIRST;
      first_hw        <= '0;
      first_pc        <= '0;
      held_hw         <= '0;
      held_imm        <= '0;
      held_pc         <= '0;
      last_dest       <= '0;
      last_r3         <= '0;
      last_live       <= 1'b0;
      circuit_sel_o   <= NOP_SEL;
      destination_o   <= '0;
      reg1_o          <= '0;
      reg2_o          <= '0;
      reg3_o          <= '0;
      increment_bit_o <= 1'b0;
      flush_o         <= 1'b0;
      illegal_o       <= 1'b0;
    end else begin
      circuit_sel_o   <= NOP_SEL;
      destination_o   <= '0;
      reg1_o          <= '0;
      reg2_o          <= '0;
      reg3_o          <= '0;
      increment_bit_o <= 1'b0;
      flush_o         <= 1'b0;
      illegal_o       <= 1'b0;
      last_dest       <= '0;
      last_r3         <= '0;
      last_live       <= 1'b0;
      if (state == FIRST && accept && instr_i[10:9] == 2'b11) begin
        first_hw <= instr_i;
        first_pc <= instr_pc_i;
        state    <= SECOND;
      end else if (go) begin
        if (hazard) begin
          held_hw  <= hw_a;
          held_imm <= hw_b;
          held_pc  <= pc_a;
          state    <= STALL;
        end else begin
          circuit_sel_o <= d_sel;
          destination_o <= d_dest;
          reg1_o        <= d_reg1;
          reg2_o        <= d_reg2;
          reg3_o        <= d_reg3;
          flush_o       <= d_flush;
          illegal_o     <= d_illegal;
          last_dest     <= d_dest;
          last_r3       <= d_reg3[4:0];
          last_live     <= (d_sel != NOP_SEL) && !d_flush;
          state         <= FIRST;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: each stimulus cycle queues the expected
// registered bundle, which the negedge monitor pops and compares.
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_i;
  logic [31:0] instr_pc_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] gr [0:31];
  logic [31:0] psw;
  logic [4:0]  destination_o;
  logic [31:0] reg1_o, reg2_o, reg3_o;
  logic        increment_bit_o;
  logic [4:0]  circuit_sel_o;
  logic        flush_o;
  logic        illegal_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [4:0]  dest;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] reg3;
    logic        flush;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  instruction_decoder #(.NOP_SEL(5'b11111)) dut (
    .clk(clk),
    .rst(rst),
    .instr_i(instr_i),
    .instr_pc_i(instr_pc_i),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .GR_i(gr),
    .PSW_i(psw),
    .destination_o(destination_o),
    .reg1_o(reg1_o),
    .reg2_o(reg2_o),
    .reg3_o(reg3_o),
    .increment_bit_o(increment_bit_o),
    .circuit_sel_o(circuit_sel_o),
    .flush_o(flush_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [4:0] sel, input logic [4:0] dest,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] r3, input logic fl, input logic il);
    exp_t e;
    e.name = ""; e.sel = sel; e.dest = dest; e.reg1 = r1; e.reg2 = r2;
    e.reg3 = r3; e.flush = fl; e.illegal = il;
    return e;
  endfunction

  function automatic exp_t nop();
    return mk(5'b11111, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".sel"},     32'(circuit_sel_o),   32'(e.sel));
      check({e.name, ".dest"},    32'(destination_o),   32'(e.dest));
      check({e.name, ".reg1"},    reg1_o,               e.reg1);
      check({e.name, ".reg2"},    reg2_o,               e.reg2);
      check({e.name, ".reg3"},    reg3_o,               e.reg3);
      check({e.name, ".inc"},     32'(increment_bit_o), 32'd0);
      check({e.name, ".flush"},   32'(flush_o),         32'(e.flush));
      check({e.name, ".illegal"}, 32'(illegal_o),       32'(e.illegal));
    end
  end

  task automatic step(input string name, input logic r, input logic v,
                      input logic [15:0] hw, input logic [31:0] pc,
                      input logic exp_ready, input exp_t e);
    rst = r; instr_valid_i = v; instr_i = hw; instr_pc_i = pc;
    #1;
    check({name, ".ready"}, 32'(instr_ready_o), 32'(exp_ready));
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string name, input logic exp_ready);
    step(name, 1'b0, 1'b0, 16'h0000, 32'd0, exp_ready, nop());
  endtask

  initial begin
    for (int unsigned i = 0; i < 32; i++) gr[i] = 32'h1000 + i;
    gr[0] = 32'hDEADBEEF; gr[1] = 32'd5; gr[2] = 32'd7; gr[3] = 32'h1234;
    gr[9] = 32'h99; gr[7] = 32'h70;
    psw = '0;
    rst = 1'b1; instr_valid_i = 1'b0; instr_i = '0; instr_pc_i = '0;
    @(negedge clk);

    step("rst0", 1'b1, 1'b1, 16'h11C1, 32'd0, 1'b0, nop());
    step("rst1", 1'b1, 1'b0, 16'h0000, 32'd0, 1'b0, nop());
    idle("idle0", 1'b1);

    step("add", 1'b0, 1'b1, 16'h11C1, 32'h10, 1'b1, mk(5'b00001, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0));
    idle("idle1", 1'b1);
    step("addi_h1", 1'b0, 1'b1, 16'h2603, 32'h20, 1'b1, nop());
    step("addi_h2", 1'b0, 1'b1, 16'hFFFF, 32'h22, 1'b1, mk(5'b00001, 5'd4, 32'hFFFFFFFF, 32'h1234, 32'd0, 1'b0, 1'b0));
    step("ori_h1", 1'b0, 1'b1, 16'h2683, 32'h24, 1'b1, nop());
    idle("ori_gap", 1'b1);
    step("ori_h2", 1'b0, 1'b1, 16'hFFFF, 32'h26, 1'b1, mk(5'b00011, 5'd4, 32'h0000FFFF, 32'h1234, 32'd0, 1'b0, 1'b0));
    step("andi_h1", 1'b0, 1'b1, 16'h26C3, 32'h28, 1'b1, nop());
    step("andi_h2", 1'b0, 1'b1, 16'h8001, 32'h2A, 1'b1, mk(5'b00010, 5'd4, 32'h00008001, 32'h1234, 32'd0, 1'b0, 1'b0));
    idle("idle2", 1'b1);

    step("raw_add", 1'b0, 1'b1, 16'h11C1, 32'h30, 1'b1, mk(5'b00001, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0));
    step("raw_sub_bubble", 1'b0, 1'b1, 16'h19A2, 32'h32, 1'b1, nop());
    gr[2] = 32'd12;
    step("raw_sub_issue", 1'b0, 1'b1, 16'h11C1, 32'h34, 1'b0, mk(5'b00000, 5'd3, 32'hFFFFFFF4, 32'h1234, 32'd0, 1'b0, 1'b0));
    idle("idle3", 1'b1);

    step("gr0_add", 1'b0, 1'b1, 16'h49C0, 32'h40, 1'b1, mk(5'b00001, 5'd9, 32'd0, 32'h99, 32'd0, 1'b0, 1'b0));
    idle("idle4", 1'b1);

    gr[1] = 32'd3; gr[2] = 32'd10; gr[5] = 32'hA0; gr[6] = 32'h0B;
    step("div_h1", 1'b0, 1'b1, 16'h17E1, 32'h50, 1'b1, nop());
    step("div_h2", 1'b0, 1'b1, 16'h2AC0, 32'h52, 1'b1, mk(5'b01000, 5'd2, 32'd3, 32'd10, 32'd5, 1'b0, 1'b0));
    step("div_r3_bubble", 1'b0, 1'b1, 16'h3105, 32'h54, 1'b1, nop());
    step("div_r3_or", 1'b0, 1'b0, 16'h0000, 32'd0, 1'b0, mk(5'b00011, 5'd6, 32'hA0, 32'h0B, 32'd0, 1'b0, 1'b0));
    idle("idle5", 1'b1);

    psw = 32'h1;
    step("bz_taken", 1'b0, 1'b1, 16'h0D82, 32'h100, 1'b1, mk(5'b00001, 5'd0, 32'h10, 32'h100, 32'd0, 1'b1, 1'b0));
    idle("bz_flush_cycle", 1'b0);
    psw = 32'h0;
    step("bz_not_taken", 1'b0, 1'b1, 16'h0D82, 32'h100, 1'b1, nop());
    step("bnz_taken", 1'b0, 1'b1, 16'h0D8A, 32'h400, 1'b1, mk(5'b00001, 5'd0, 32'h10, 32'h400, 32'd0, 1'b1, 1'b0));
    idle("bnz_flush_cycle", 1'b0);

    step("add_imm5", 1'b0, 1'b1, 16'h3A5F, 32'h200, 1'b1, mk(5'b00001, 5'd7, 32'hFFFFFFFF, 32'h70, 32'd0, 1'b0, 1'b0));
    step("br_flag_bubble", 1'b0, 1'b1, 16'hFDE5, 32'h202, 1'b1, nop());
    step("br_issue", 1'b0, 1'b0, 16'h0000, 32'd0, 1'b0, mk(5'b00001, 5'd0, 32'hFFFFFFFC, 32'h202, 32'd0, 1'b1, 1'b0));
    idle("br_flush_cycle", 1'b0);

    psw = 32'h10;
    step("bsa_taken", 1'b0, 1'b1, 16'h058D, 32'h300, 1'b1, mk(5'b00001, 5'd0, 32'd0, 32'h300, 32'd0, 1'b1, 1'b0));
    idle("bsa_flush_cycle", 1'b0);
    psw = 32'h0F;
    step("bsa_not_taken", 1'b0, 1'b1, 16'h058D, 32'h300, 1'b1, nop());
    psw = 32'h0;

    step("ill32_h1", 1'b0, 1'b1, 16'h07C0, 32'h500, 1'b1, nop());
    step("ill32_h2", 1'b0, 1'b1, 16'h0000, 32'h502, 1'b1, mk(5'b11111, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1));
    step("ill16", 1'b0, 1'b1, 16'h0000, 32'h504, 1'b1, mk(5'b11111, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1));
    idle("idle6", 1'b1);

    step("mid_h1", 1'b0, 1'b1, 16'h2603, 32'h600, 1'b1, nop());
    step("mid_rst", 1'b1, 1'b1, 16'hFFFF, 32'h602, 1'b0, nop());
    step("post_rst_add", 1'b0, 1'b1, 16'h11C1, 32'h604, 1'b1, mk(5'b00001, 5'd2, 32'd3, 32'd10, 32'd0, 1'b0, 1'b0));
    idle("idle7", 1'b1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
